cic_agc_ctrl: RTL

- Automatic gain controller for the CIC decimator's `gain` input.
- Samples CIC output on each rising edge of the decimated `data_clk` and tracks the peak magnitude over a window of samples.
- Steps gain by ±1 with hysteresis, then waits for the CIC comb pipeline to flush before measuring again.
- Supports a manual gain load and reports a locked status.

---
 rtl/cic_agc_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cic_agc_ctrl.sv
// cic_agc_ctrl: automatic gain control loop for the CIC decimator gain input.
// Tracks the peak magnitude over a window of decimated samples, steps gain by
// +/-1 with hysteresis, then waits for the comb pipeline to flush.
// Optional build macro: CIC_AGC_FAST_ATTACK_EN (clipped sample drops gain at once).
module cic_agc_ctrl #(
  parameter int unsigned INPUT_WIDTH    = 12,
  parameter int unsigned GAIN_WIDTH     = 8,
  parameter int unsigned GAIN_MAX       = 52,
  parameter int unsigned GAIN_INIT      = 0,
  parameter int unsigned WINDOW_LOG2    = 8,
  parameter int unsigned SETTLE_SAMPLES = 8,
  parameter int unsigned HIGH_THRESH    = 1536,
  parameter int unsigned LOW_THRESH     = 512
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   enable,
  input  logic [GAIN_WIDTH-1:0]  manual_gain,
  input  logic                   manual_load,
  input  logic [INPUT_WIDTH-1:0] sample_in,
  input  logic                   sample_clk,
  output logic [GAIN_WIDTH-1:0]  gain,
  output logic                   gain_update,
  output logic                   locked,
  output logic [INPUT_WIDTH-2:0] peak
);

  localparam int unsigned MAG_W = INPUT_WIDTH - 1;
  localparam int unsigned SET_W = $clog2(SETTLE_SAMPLES + 1);
  localparam int unsigned CNT_W = (WINDOW_LOG2 > SET_W) ? WINDOW_LOG2 : SET_W;

  localparam logic [CNT_W-1:0]       WIN_LAST = CNT_W'((2 ** WINDOW_LOG2) - 1);
  localparam logic [CNT_W-1:0]       SET_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [GAIN_WIDTH-1:0]  G_MAX    = GAIN_WIDTH'(GAIN_MAX);
  localparam logic [GAIN_WIDTH-1:0]  G_INIT   = GAIN_WIDTH'(GAIN_INIT);
  localparam logic [INPUT_WIDTH-1:0] HI_T     = INPUT_WIDTH'(HIGH_THRESH);
  localparam logic [INPUT_WIDTH-1:0] LO_T     = INPUT_WIDTH'(LOW_THRESH);
  localparam logic [MAG_W-1:0]       MAG_MAX  = {MAG_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    EVAL    = 2'd2,
    SETTLE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MAG_W-1:0]        acc_q, acc_d;
  logic [GAIN_WIDTH-1:0]   gain_q, gain_d;
  logic                    gain_update_q, gain_update_d;
  logic                    locked_q, locked_d;
  logic [MAG_W-1:0]        peak_q, peak_d;
  logic                    sample_clk_q, sample_clk_d;

  logic                    strobe_c;
  logic [INPUT_WIDTH-1:0]  abs_full_c;
  logic [MAG_W-1:0]        mag_c;

  // Rising-edge detect on the decimated sample clock and saturated |sample_in|.
  always_comb begin
    sample_clk_d = sample_clk;
    strobe_c     = sample_clk & ~sample_clk_q;
    abs_full_c   = sample_in[INPUT_WIDTH-1] ? (~sample_in + INPUT_WIDTH'(1)) : sample_in;
    // Only the most negative code leaves the MSB set after negation.
    mag_c        = abs_full_c[INPUT_WIDTH-1] ? MAG_MAX : abs_full_c[MAG_W-1:0];
  end

  // Next-state and output logic; manual load beats enable, enable beats the loop.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    gain_d        = gain_q;
    gain_update_d = 1'b0;
    locked_d      = locked_q;
    peak_d        = peak_q;

    if (manual_load) begin
      gain_d        = (manual_gain > G_MAX) ? G_MAX : manual_gain;
      gain_update_d = (gain_d != gain_q);
      locked_d      = 1'b0;
      cnt_d         = '0;
      acc_d         = '0;
      state_d       = enable ? SETTLE : IDLE;
    end else if (!enable) begin
      locked_d = 1'b0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          acc_d   = '0;
          state_d = MEASURE;
        end
        MEASURE: begin
          if (strobe_c) begin
            acc_d = (mag_c > acc_q) ? mag_c : acc_q;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == WIN_LAST) begin
              cnt_d   = '0;
              state_d = EVAL;
            end
`ifdef CIC_AGC_FAST_ATTACK_EN
            // Clipping means the gain is already too high; react without waiting.
            if ((mag_c == MAG_MAX) && (gain_q != '0)) begin
              peak_d        = MAG_MAX;
              gain_d        = gain_q - GAIN_WIDTH'(1);
              gain_update_d = 1'b1;
              locked_d      = 1'b0;
              cnt_d         = '0;
              state_d       = SETTLE;
            end
`endif
          end
        end
        EVAL: begin
          peak_d = acc_q;
          acc_d  = '0;
          cnt_d  = '0;
          if (({1'b0, acc_q} >= HI_T) && (gain_q != '0)) begin
            gain_d        = gain_q - GAIN_WIDTH'(1);
            gain_update_d = 1'b1;
            locked_d      = 1'b0;
            state_d       = SETTLE;
          end else if (({1'b0, acc_q} < LO_T) && (gain_q < G_MAX)) begin
            gain_d        = gain_q + GAIN_WIDTH'(1);
            gain_update_d = 1'b1;
            locked_d      = 1'b0;
            state_d       = SETTLE;
          end else begin
            locked_d = 1'b1;
            state_d  = MEASURE;
          end
        end
        SETTLE: begin
          if (strobe_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == SET_LAST) begin
              cnt_d   = '0;
              acc_d   = '0;
              state_d = MEASURE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      gain_q        <= G_INIT;
      gain_update_q <= 1'b0;
      locked_q      <= 1'b0;
      peak_q        <= '0;
      sample_clk_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      gain_q        <= gain_d;
      gain_update_q <= gain_update_d;
      locked_q      <= locked_d;
      peak_q        <= peak_d;
      sample_clk_q  <= sample_clk_d;
    end
  end

  assign gain        = gain_q;
  assign gain_update = gain_update_q;
  assign locked      = locked_q;
  assign peak        = peak_q;

endmodule
